vga_frame_decoder: RTL and testbench
====================================

Name: vga_frame_decoder

Overview:
Receive-side counterpart of the game's VGA output. Monitors the VGA_hSync/VGA_vSync/VGA_R/G/B pins, samples the centre pixel of every grid cell, and rebuilds the 192-bit game matrix (16 rows x 12 cols), one snapshot per frame. Used on-board for self-test/loopback and in benches as a scoreboard against the data bus driving the display.

Parameters:
PIX_DIV, 2, system clocks per VGA pixel (50 MHz -> 25 MHz)
H_OFFSET, 144, pixels from hSync falling edge to first visible pixel (sync 96 + back porch 48)
V_OFFSET, 35, lines from vSync falling edge to first visible line (sync 2 + back porch 33)
ORIGIN_X, 80, visible x of grid left edge
ORIGIN_Y, 0, visible y of grid top edge
CELL_W, 40, cell width in pixels
CELL_H, 30, cell height in lines
ROWS, 16, grid rows
COLS, 12, grid columns
LIT_THRESH, 8, minimum channel value (4-bit) counted as lit

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
VGA_hSync  in  1  horizontal sync, active low
VGA_vSync  in  1  vertical sync, active low
VGA_R  in  4  red channel
VGA_G  in  4  green channel
VGA_B  in  4  blue channel
data_out  out  192  last complete frame, bit index = row*COLS + col, row 0 top, col 0 left
frame_valid  out  1  one-cycle pulse when data_out updates
frame_count  out  8  count of accepted frames, wraps 255->0
sync_error  out  1  sticky malformed-timing flag

Behaviour:
- One clock; reset is synchronous and active-high. On reset: data_out=0, frame_valid=0, frame_count=0, sync_error=0, all counters, shadow register and arm flag cleared.
- Sync and RGB inputs pass through a 2-flop synchroniser; edges are detected on synchronised signals (2-3 clock latency, fixed and identical for all inputs).
- Pixel counter (10 bit): cleared, with its PIX_DIV prescaler, on hSync falling edge; then +1 every PIX_DIV clocks; saturates at 1023.
- Line counter (10 bit): cleared on vSync falling edge; otherwise +1 per hSync falling edge; saturates at 1023. If both edges occur in the same cycle, vSync wins (line=0).
- Sample point for cell (r,c): pixel = H_OFFSET+ORIGIN_X+c*CELL_W+CELL_W/2, line = V_OFFSET+ORIGIN_Y+r*CELL_H+CELL_H/2. Sample taken on the first clock of that pixel (prescaler=0). Multipliers are not required; step counters are allowed.
- Lit = any of R, G or B >= LIT_THRESH. Lit writes bit r*COLS+c of the shadow register. An 8-bit sample counter counts samples taken this frame.
- FSM: ARM -> RUN. ARM (after reset): wait for the first vSync falling edge, then clear shadow and sample count and go to RUN. No output, no error.
- RUN, on each vSync falling edge:
  - If sample count == ROWS*COLS (192): copy shadow to data_out, assert frame_valid for exactly one cycle on the next clock, increment frame_count.
  - Otherwise: set sync_error; leave data_out, frame_valid and frame_count unchanged.
  - Either way: clear shadow and sample count.
- sync_error also sets on pixel-counter saturation (no hSync for 1023 pixels) or line-counter saturation. It clears only on reset. Decoding continues after an error.
- Reset mid-frame discards the partial frame and returns to ARM.

Optional Feature:
STABLE_FILTER_EN: when defined, a completed frame is committed only if its shadow equals the previous completed frame (second 192-bit register). Mismatch: no update, no pulse, no error, candidate replaced. When undefined, every complete frame commits immediately.

Test Plan:
- Reset, then drive 640x480@60 timing with all-black RGB for 2 frames -> first vSync arms; frame_valid pulses once at 2nd vSync edge, data_out=0, frame_count=1.
- Cells (0,0), (15,11) and (7,5) white (F,F,F), rest black -> data_out bits 0, 191, 89 set, all others 0, frame_count increments per frame.
- Cell (3,3) driven R=7,G=0,B=0 then R=8 -> bit 39 reads 0 then 1 (threshold boundary).
- Stop hSync for 1100 pixels mid-frame -> sync_error=1, no frame_valid at next vSync; resume timing -> next complete frame commits, sync_error stays 1 until reset.
- Run 256 good frames -> frame_count wraps 255->0, frame_valid each frame; assert reset mid-frame -> all outputs 0, next vSync arms only.
- With STABLE_FILTER_EN: alternate patterns A,B,A,B -> no commits; then A,A -> commit A on second frame.

Source files
------------

// File: rtl/vga_frame_decoder.sv
// VGA receive-side decoder: samples each grid cell centre and rebuilds the ROWS*COLS lit matrix once per frame.
// Optional STABLE_FILTER_EN: commit a frame only when it matches the previous completed frame.
module vga_frame_decoder #(
  parameter int PIX_DIV    = 2,
  parameter int H_OFFSET   = 144,
  parameter int V_OFFSET   = 35,
  parameter int ORIGIN_X   = 80,
  parameter int ORIGIN_Y   = 0,
  parameter int CELL_W     = 40,
  parameter int CELL_H     = 30,
  parameter int ROWS       = 16,
  parameter int COLS       = 12,
  parameter int LIT_THRESH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   VGA_hSync,
  input  logic                   VGA_vSync,
  input  logic [3:0]             VGA_R,
  input  logic [3:0]             VGA_G,
  input  logic [3:0]             VGA_B,
  output logic [ROWS*COLS-1:0]   data_out,
  output logic                   frame_valid,
  output logic [7:0]             frame_count,
  output logic                   sync_error
);

  localparam int NB = ROWS * COLS;
  localparam int IW = $clog2(NB);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0]    MAX10     = 10'd1023;
  localparam logic [9:0]    COL0      = 10'(H_OFFSET + ORIGIN_X + CELL_W / 2);
  localparam logic [9:0]    ROW0      = 10'(V_OFFSET + ORIGIN_Y + CELL_H / 2);
  localparam logic [9:0]    STEP_X    = 10'(CELL_W);
  localparam logic [9:0]    STEP_Y    = 10'(CELL_H);
  localparam logic [RW-1:0] ROWS_L    = RW'(ROWS);
  localparam logic [CW-1:0] COLS_L    = CW'(COLS);
  localparam logic [IW-1:0] COLS_I    = IW'(COLS);
  localparam logic [PW-1:0] PRESC_TOP = PW'(PIX_DIV - 1);
  localparam logic [7:0]    NB_L      = 8'(NB);
  localparam logic [3:0]    THR       = 4'(LIT_THRESH);
  localparam logic [13:0]   SYNC_IDLE = 14'b11_0000_0000_0000;

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  // {hSync, vSync, R, G, B}; three identical stages keep RGB aligned with the edge-derived pixel count
  logic [13:0]   r_s1, r_s2, r_s3;
  logic [PW-1:0] r_presc;
  logic [9:0]    r_pix, r_line, r_row_ln, r_col_px;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [IW-1:0] r_row_base;
  state_t        r_state;
  logic [NB-1:0] r_shadow, r_data;
  logic [7:0]    r_samp_cnt, r_frame_count;
  logic          r_frame_valid, r_sync_error;
`ifdef STABLE_FILTER_EN
  logic [NB-1:0] r_prev;
`endif

  logic          w_hs_fall, w_vs_fall, w_take, w_lit;
  logic [IW-1:0] w_idx;
  logic [NB-1:0] w_hit, w_shadow_upd;
  logic [7:0]    w_cnt_upd;

  assign w_hs_fall = r_s3[13] & ~r_s2[13];
  assign w_vs_fall = r_s3[12] & ~r_s2[12];
  assign w_lit     = (r_s3[11:8] >= THR) || (r_s3[7:4] >= THR) || (r_s3[3:0] >= THR);
  assign w_take    = (r_row != ROWS_L) && (r_col != COLS_L) && (r_line == r_row_ln) &&
                     (r_pix == r_col_px) && (r_presc == '0);
  assign w_idx     = r_row_base + IW'(r_col);
  assign w_hit     = {{(NB-1){1'b0}}, 1'b1} << w_idx;
  // A sample landing in the same cycle as the vSync edge still belongs to the closing frame
  assign w_shadow_upd = (w_take && w_lit) ? (r_shadow | w_hit) : r_shadow;
  assign w_cnt_upd    = r_samp_cnt + 8'(w_take);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1       <= SYNC_IDLE;
      r_s2       <= SYNC_IDLE;
      r_s3       <= SYNC_IDLE;
      r_presc    <= '0;
      r_pix      <= '0;
      r_line     <= '0;
      r_row      <= '0;
      r_row_ln   <= ROW0;
      r_row_base <= '0;
      r_col      <= '0;
      r_col_px   <= COL0;
    end else begin
      r_s1 <= {VGA_hSync, VGA_vSync, VGA_R, VGA_G, VGA_B};
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_hs_fall) begin
        r_presc <= '0;
        r_pix   <= '0;
      end else if (r_presc == PRESC_TOP) begin
        r_presc <= '0;
        if (r_pix != MAX10) r_pix <= r_pix + 10'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_vs_fall)                        r_line <= '0;
      else if (w_hs_fall && r_line != MAX10) r_line <= r_line + 10'd1;

      // Row stepping: move to the next row once its sample line has ended
      if (w_vs_fall) begin
        r_row      <= '0;
        r_row_ln   <= ROW0;
        r_row_base <= '0;
      end else if (w_hs_fall && r_row != ROWS_L && r_line == r_row_ln) begin
        r_row      <= r_row + RW'(1);
        r_row_ln   <= r_row_ln + STEP_Y;
        r_row_base <= r_row_base + COLS_I;
      end

      if (w_hs_fall || w_vs_fall) begin
        r_col    <= '0;
        r_col_px <= COL0;
      end else if (w_take) begin
        r_col    <= r_col + CW'(1);
        r_col_px <= r_col_px + STEP_X;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_ARM;
      r_shadow      <= '0;
      r_samp_cnt    <= '0;
      r_data        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
      r_sync_error  <= 1'b0;
`ifdef STABLE_FILTER_EN
      r_prev        <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_shadow      <= w_shadow_upd;
      r_samp_cnt    <= w_cnt_upd;
      if (w_vs_fall) begin
        r_shadow   <= '0;
        r_samp_cnt <= '0;
        if (r_state == ST_ARM) begin
          r_state <= ST_RUN;
        end else if (w_cnt_upd == NB_L) begin
`ifdef STABLE_FILTER_EN
          r_prev <= w_shadow_upd;
          if (w_shadow_upd == r_prev) begin
            r_data        <= w_shadow_upd;
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
          end
`else
          r_data        <= w_shadow_upd;
          r_frame_valid <= 1'b1;
          r_frame_count <= r_frame_count + 8'd1;
`endif
        end else begin
          r_sync_error <= 1'b1;
        end
      end
      if (r_state == ST_RUN && (r_pix == MAX10 || r_line == MAX10)) r_sync_error <= 1'b1;
    end
  end

  assign data_out    = r_data;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;
  assign sync_error  = r_sync_error;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed bench for vga_frame_decoder using a compact timing: 1 clock/pixel, 15-pixel lines, 17-line frames.
module tb_vga_frame_decoder;

  localparam int LINE_PIX = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         VGA_hSync, VGA_vSync;
  logic [3:0]   VGA_R, VGA_G, VGA_B;
  logic [191:0] data_out;
  logic         frame_valid;
  logic [7:0]   frame_count;
  logic         sync_error;

  always #5 clk = ~clk;

  vga_frame_decoder #(
    .PIX_DIV(1), .H_OFFSET(2), .V_OFFSET(1), .ORIGIN_X(0), .ORIGIN_Y(0),
    .CELL_W(1), .CELL_H(1), .ROWS(16), .COLS(12), .LIT_THRESH(8)
  ) dut (
    .clock(clk), .reset(reset),
    .VGA_hSync(VGA_hSync), .VGA_vSync(VGA_vSync),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .data_out(data_out), .frame_valid(frame_valid),
    .frame_count(frame_count), .sync_error(sync_error)
  );

  typedef struct {
    logic [191:0] mask;
    int           sp_idx;
    logic [11:0]  sp_rgb;
    logic         exp_commit;
    logic [191:0] exp_data;
  } vec_t;

  vec_t         vecs[8];
  int           nvec;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           pulses  = 0;
  int           exp_cnt = 0;
  logic [191:0] exp_data = '0;

  always @(negedge clk) if (frame_valid === 1'b1) pulses++;

  function automatic logic [191:0] bit_at(input int i);
    logic [191:0] one;
    one = 192'd1;
    return one << i;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One line: pixel 0 carries the hSync pulse, pixels 2..13 are the 12 cells of 'row'
  task automatic line(input logic vs_low, input int row, input logic [191:0] mask,
                      input int sp_idx, input logic [11:0] sp_rgb);
    int          idx;
    logic [11:0] c;
    for (int p = 0; p < LINE_PIX; p++) begin
      c = 12'h000;
      if (row >= 0 && p >= 2 && p < 14) begin
        idx = row * 12 + p - 2;
        if (idx == sp_idx)  c = sp_rgb;
        else if (mask[idx]) c = 12'hFFF;
      end
      VGA_hSync = (p != 0);
      VGA_vSync = ~vs_low;
      {VGA_R, VGA_G, VGA_B} = c;
      @(posedge clk); #1;
    end
  endtask

  task automatic vsync_line();
    line(1'b1, -1, '0, -1, 12'h000);
  endtask

  task automatic data_lines(input int first, input int last, input logic [191:0] mask,
                            input int sp_idx, input logic [11:0] sp_rgb);
    for (int r = first; r <= last; r++) line(1'b0, r, mask, sp_idx, sp_rgb);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p0, n;
    logic [191:0] m;
    VGA_hSync = 1'b1; VGA_vSync = 1'b1;
    {VGA_R, VGA_G, VGA_B} = 12'h000;
    do_reset();
    chk("rst_data", data_out, '0);
    chk("rst_valid", 192'(frame_valid), 192'd0);
    chk("rst_count", 192'(frame_count), 192'd0);
    chk("rst_err", 192'(sync_error), 192'd0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef STABLE_FILTER_EN
    nvec = 6;
    for (int i = 0; i < 6; i++) begin
      vecs[i] = '{mask: ((i % 2) == 0 || i == 5) ? (bit_at(0) | bit_at(191)) : bit_at(89),
                  sp_idx: -1, sp_rgb: 12'h000, exp_commit: 1'b0, exp_data: '0};
    end
    vecs[5].exp_commit = 1'b1;
    vecs[5].exp_data   = bit_at(0) | bit_at(191);
`else
    nvec = 8;
    vecs[0] = '{mask: '0, sp_idx: -1, sp_rgb: 12'h000, exp_commit: 1'b1, exp_data: '0};
    vecs[1] = '{mask: bit_at(0) | bit_at(191) | bit_at(89), sp_idx: -1, sp_rgb: 12'h000,
                exp_commit: 1'b1, exp_data: bit_at(0) | bit_at(191) | bit_at(89)};
    vecs[2] = vecs[1];
    vecs[3] = '{mask: '0, sp_idx: 39, sp_rgb: 12'h700, exp_commit: 1'b1, exp_data: '0};
    vecs[4] = '{mask: '0, sp_idx: 39, sp_rgb: 12'h800, exp_commit: 1'b1, exp_data: bit_at(39)};
    vecs[5] = '{mask: '0, sp_idx: 39, sp_rgb: 12'h080, exp_commit: 1'b1, exp_data: bit_at(39)};
    vecs[6] = '{mask: bit_at(5), sp_idx: 100, sp_rgb: 12'h00F, exp_commit: 1'b1,
                exp_data: bit_at(5) | bit_at(100)};
    vecs[7] = '{mask: '0, sp_idx: 39, sp_rgb: 12'h777, exp_commit: 1'b1, exp_data: '0};
`endif

    // First vSync only arms the decoder
    p0 = pulses;
    vsync_line();
    @(negedge clk);
    chk("arm_pulse", 192'(pulses - p0), 192'd0);
    chk("arm_count", 192'(frame_count), 192'd0);

    for (int i = 0; i < nvec; i++) begin
      p0 = pulses;
      data_lines(0, 15, vecs[i].mask, vecs[i].sp_idx, vecs[i].sp_rgb);
      vsync_line();
      @(negedge clk);
      if (vecs[i].exp_commit) begin
        exp_cnt  = (exp_cnt + 1) % 256;
        exp_data = vecs[i].exp_data;
      end
      chk($sformatf("vec%0d_pulse", i), 192'(pulses - p0), 192'(vecs[i].exp_commit));
      chk($sformatf("vec%0d_data", i), data_out, exp_data);
      chk($sformatf("vec%0d_count", i), 192'(frame_count), 192'(exp_cnt));
      chk($sformatf("vec%0d_err", i), 192'(sync_error), 192'd0);
    end

`ifndef STABLE_FILTER_EN
    // hSync stalls for 1100 pixels mid-frame: pixel counter saturates
    data_lines(0, 4, bit_at(7), -1, 12'h000);
    repeat (1100) begin
      VGA_hSync = 1'b1; VGA_vSync = 1'b1; {VGA_R, VGA_G, VGA_B} = 12'h000;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_err", 192'(sync_error), 192'd1);
    p0 = pulses;
    vsync_line();
    @(negedge clk);
    chk("stall_pulse", 192'(pulses - p0), 192'd0);
    chk("stall_count", 192'(frame_count), 192'(exp_cnt));
    chk("stall_data", data_out, exp_data);

    p0 = pulses;
    m  = bit_at(17) | bit_at(150);
    data_lines(0, 15, m, -1, 12'h000);
    vsync_line();
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("resume_pulse", 192'(pulses - p0), 192'd1);
    chk("resume_data", data_out, m);
    chk("resume_count", 192'(frame_count), 192'(exp_cnt));
    chk("resume_err", 192'(sync_error), 192'd1);

    // Run good frames until frame_count wraps 255 -> 0
    n = 256 - exp_cnt;
    for (int k = 0; k < n; k++) begin
      p0 = pulses;
      m  = bit_at(k % 192);
      data_lines(0, 15, m, -1, 12'h000);
      vsync_line();
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % 256;
      chk($sformatf("wrap%0d_pulse", k), 192'(pulses - p0), 192'd1);
      chk($sformatf("wrap%0d_count", k), 192'(frame_count), 192'(exp_cnt));
      chk($sformatf("wrap%0d_data", k), data_out, m);
    end
    chk("wrap_zero", 192'(frame_count), 192'd0);
    chk("wrap_err_sticky", 192'(sync_error), 192'd1);

    // Reset mid-frame: partial frame discarded, next vSync only re-arms
    data_lines(0, 7, bit_at(3), -1, 12'h000);
    do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_data", data_out, '0);
    chk("mrst_valid", 192'(frame_valid), 192'd0);
    chk("mrst_count", 192'(frame_count), 192'd0);
    chk("mrst_err", 192'(sync_error), 192'd0);
    data_lines(8, 15, bit_at(3), -1, 12'h000);
    p0 = pulses;
    vsync_line();
    @(negedge clk);
    chk("mrst_arm_pulse", 192'(pulses - p0), 192'd0);
    p0 = pulses;
    m  = bit_at(60) | bit_at(61);
    data_lines(0, 15, m, -1, 12'h000);
    vsync_line();
    @(negedge clk);
    chk("mrst_pulse", 192'(pulses - p0), 192'd1);
    chk("mrst_new_data", data_out, m);
    chk("mrst_new_count", 192'(frame_count), 192'd1);
    chk("mrst_new_err", 192'(sync_error), 192'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
